// File: rtl/sc_mul_seq_if.sv
// Operand/result handshake and product-stream bundle for the sequential SC multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface sc_mul_seq_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned PAR = 4
);
  localparam int unsigned W = N + 1;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_count;
  logic           bs_valid;
  logic [PAR-1:0] bs_data;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_count, bs_valid, bs_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_count, bs_valid, bs_data
  );
endinterface

// File: rtl/sc_mul_seq.sv
// Sequential stochastic-computing multiplier: PAR stream bits per cycle, popcount result
// returned over valid/ready. A uses a bit-reversed sequence, B a linear counter.
module sc_mul_seq #(
  parameter int unsigned N   = 4,
  parameter int unsigned PAR = 4
) (
  input  logic         clk,
  input  logic         rst,
  sc_mul_seq_if.slave  bus
);
  localparam int unsigned W = N + 1;
  localparam int unsigned L = 1 << N;
  localparam logic [N-1:0] IDX_STEP = N'(PAR);
  localparam logic [N-1:0] LAST_IDX = N'(L - PAR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           mode_q, mode_d;
  logic [W-1:0]   count_q, count_d;

  logic [PAR-1:0] bit_a_c, bit_b_c, stream_c;
  logic [W-1:0]   pop_c;
  logic           ready_c, accept_c, out_valid_c, bs_valid_c;

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < int'(N); k++) r[k] = v[int'(N) - 1 - k];
    return r;
  endfunction

  // Stream chunk for indices idx..idx+PAR-1 and its popcount.
  always_comb begin
    bit_a_c  = '0;
    bit_b_c  = '0;
    stream_c = '0;
    pop_c    = '0;
    for (int j = 0; j < int'(PAR); j++) begin
      bit_a_c[j]  = a_q > {1'b0, bit_rev(idx_q + N'(j))};
      bit_b_c[j]  = b_q > {1'b0, idx_q + N'(j)};
      stream_c[j] = mode_q ? ~(bit_a_c[j] ^ bit_b_c[j]) : (bit_a_c[j] & bit_b_c[j]);
      pop_c       = pop_c + W'(stream_c[j]);
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    count_d     = count_q;
    ready_c     = 1'b0;
    accept_c    = 1'b0;
    out_valid_c = 1'b0;
    bs_valid_c  = 1'b0;

    ready_c  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    accept_c = bus.in_valid & ready_c;

    case (state_q)
      IDLE: ;
      RUN: begin
        bs_valid_c = 1'b1;
        acc_d      = acc_q + pop_c;
        idx_d      = idx_q + IDX_STEP;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          count_d = acc_q + pop_c;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An accept in DONE overrides the return to IDLE, giving back-to-back operation.
    if (accept_c) begin
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      mode_d  = bus.in_mode;
      idx_d   = '0;
      acc_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_count = count_q;
  assign bus.bs_valid  = bs_valid_c;
  assign bus.bs_data   = bs_valid_c ? stream_c : '0;

endmodule

// File: tb/tb_sc_mul_seq.sv
// Scoreboard bench for sc_mul_seq: directed plan cases, backpressure, mid-run reset,
// randomized traffic against a behavioural model, plus PAR=1 and PAR=16 instances.
module tb_sc_mul_seq;
  localparam int N   = 4;
  localparam int PAR = 4;
  localparam int L   = 1 << N;
  localparam int C   = L / PAR;
  localparam int W   = N + 1;

  logic clk;
  logic rst;

  sc_mul_seq_if #(.N(N), .PAR(PAR)) bus ();
  sc_mul_seq_if #(.N(N), .PAR(1))   if1 ();
  sc_mul_seq_if #(.N(N), .PAR(16))  if16 ();

  sc_mul_seq #(.N(N), .PAR(PAR)) dut (.clk(clk), .rst(rst), .bus(bus));
  sc_mul_seq #(.N(N), .PAR(1))   u1  (.clk(clk), .rst(rst), .bus(if1));
  sc_mul_seq #(.N(N), .PAR(16))  u16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt[$];
  int exp_bs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference model straight from the stream definition.
  function automatic int rev_idx(input int i);
    int r = 0;
    int t = i;
    for (int k = 0; k < N; k++) begin
      r = r * 2 + t % 2;
      t = t / 2;
    end
    return r;
  endfunction

  function automatic int prod_bit(input int a, input int b, input int m, input int i);
    int ba = (a > rev_idx(i)) ? 1 : 0;
    int bb = (b > i) ? 1 : 0;
    if (m != 0) return (ba == bb) ? 1 : 0;
    return ba & bb;
  endfunction

  task automatic push_expect(input int a, input int b, input int m);
    int total = 0;
    for (int k = 0; k < C; k++) begin
      int bits = 0;
      for (int j = 0; j < PAR; j++) begin
        int p = prod_bit(a, b, m, k * PAR + j);
        bits  = bits | (p << j);
        total = total + p;
      end
      exp_bs.push_back(bits);
    end
    exp_cnt.push_back(total);
  endtask

  // Monitor: checks every stream chunk and every result handshake, records accepts.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt.delete();
      exp_bs.delete();
    end else begin
      if (bus.bs_valid) begin
        if (exp_bs.size() == 0) chk("bs_unexpected", 1, 0);
        else chk("sb_bs_data", int'(bus.bs_data), exp_bs.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_cnt.size() == 0) chk("out_unexpected", 1, 0);
        else chk("sb_out_count", int'(bus.out_count), exp_cnt.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        push_expect(int'(bus.in_a), int'(bus.in_b), int'(bus.in_mode));
    end
  end

  task automatic do_op(input int a, input int b, input int m, input int exp, input int first_bs);
    int n;
    @(posedge clk); #1;
    bus.in_a      = W'(a);
    bus.in_b      = W'(b);
    bus.in_mode   = m[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (first_bs >= 0) chk("first_bs_data", int'(bus.bs_data), first_bs);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("op_out_valid", int'(bus.out_valid), 1);
    chk("op_out_count", int'(bus.out_count), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nbs, first_ov, ops, cyc;
    logic acc_last;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = 1'b0; bus.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_mode = 1'b0; if1.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_mode = 1'b0; if16.out_ready = 1'b1;

    // Reset state
    repeat (2) begin @(negedge clk); chk("rst_in_ready", int'(bus.in_ready), 0); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_bs_valid", int'(bus.bs_valid), 0);
    chk("rst_bs_data", int'(bus.bs_data), 0);
    chk("idle_in_ready", int'(bus.in_ready), 1);

    // Latency: 8*8 unipolar
    @(posedge clk); #1;
    bus.in_a = 5'd8; bus.in_b = 5'd8; bus.in_mode = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    nbs = 0; first_ov = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (bus.bs_valid) nbs++;
      if (bus.out_valid && first_ov == 0) begin
        first_ov = k;
        chk("lat_out_count", int'(bus.out_count), 4);
      end
    end
    chk("lat_bs_cycles", nbs, C);
    chk("lat_first_out_valid", first_ov, C + 1);

    // Plan values
    do_op(12, 12, 0, 9, 7);
    do_op(4, 4, 0, 1, -1);
    do_op(31, 16, 0, 16, -1);
    do_op(0, 16, 0, 0, -1);
    do_op(8, 8, 1, 8, -1);
    do_op(16, 0, 1, 0, -1);
    do_op(0, 0, 1, 16, -1);
    do_op(16, 16, 1, 16, -1);

    // Backpressure and bubble-free back-to-back accept
    @(posedge clk); #1;
    bus.in_a = 5'd8; bus.in_b = 5'd8; bus.in_mode = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_a = 5'd16; bus.in_b = 5'd16; bus.in_mode = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 3; c++) begin
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_count", int'(bus.out_count), 4);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_bs_valid", int'(bus.bs_valid), 0);
      @(posedge clk); #1;
      if (c < 2) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_bs_valid", int'(bus.bs_valid), 1);
    chk("b2b_out_valid", int'(bus.out_valid), 0);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("b2b_out_count", int'(bus.out_count), 16);
    @(posedge clk); #1;

    // Reset in the second RUN cycle
    bus.in_a = 5'd12; bus.in_b = 5'd12; bus.in_mode = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_bs_valid", int'(bus.bs_valid), 0);
    chk("midrst_out_count", int'(bus.out_count), 0);
    chk("midrst_bs_data", int'(bus.bs_data), 0);
    chk("midrst_in_ready_idle", int'(bus.in_ready), 1);
    do_op(12, 12, 0, 9, 7);

    // Randomized traffic with random consumer backpressure
    ops = 0; cyc = 0; acc_last = 1'b1;
    bus.in_valid = 1'b0;
    while ((ops < 60 || bus.in_valid) && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (!bus.in_valid || acc_last) begin
        if (ops < 60 && $urandom_range(0, 3) != 0) begin
          bus.in_a     = W'($urandom_range(0, 31));
          bus.in_b     = W'($urandom_range(0, 31));
          bus.in_mode  = 1'($urandom_range(0, 1));
          bus.in_valid = 1'b1;
          ops++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc_last = bus.in_valid && bus.in_ready;
    end
    if (cyc >= 4000) chk("random_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n = 0;
    while (exp_cnt.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_pending", exp_cnt.size(), 0);

    // PAR=1 instance
    @(posedge clk); #1;
    if1.in_a = 5'd4; if1.in_b = 5'd4; if1.in_mode = 1'b0; if1.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 if1.in_valid = 1'b0;
    nbs = 0; n = 0;
    @(negedge clk);
    while (!if1.out_valid && n < 100) begin
      if (if1.bs_valid) nbs++;
      @(negedge clk); n++;
    end
    chk("par1_run_cycles", nbs, 16);
    chk("par1_out_count", int'(if1.out_count), 1);

    // PAR=16 instance
    @(posedge clk); #1;
    if16.in_a = 5'd4; if16.in_b = 5'd4; if16.in_mode = 1'b0; if16.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 if16.in_valid = 1'b0;
    nbs = 0; n = 0;
    @(negedge clk);
    chk("par16_bs_data", int'(if16.bs_data), 1);
    while (!if16.out_valid && n < 100) begin
      if (if16.bs_valid) nbs++;
      @(negedge clk); n++;
    end
    chk("par16_run_cycles", nbs, 1);
    chk("par16_out_count", int'(if16.out_count), 1);

    @(posedge clk); #1;
    @(negedge clk);
    chk("final_bs_pending", exp_bs.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
